store_buffer: RTL
=================

Name: store_buffer

Overview:
- In-order store queue between the execute/commit stage and the data-memory write port of `mem`.
- Accepts committed stores, holds up to DEPTH of them, and drains one per cycle onto `mem`'s `we/wa/wd/wm` when draining is enabled.
- Provides word-granular store-to-load forwarding, or a stall, to the load path that reads `dmem`. Loads therefore never see stale memory.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- DEPTH_LOG, $clog2(DEPTH), pointer width; derived, never overridden.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- st_valid  input  1  committed store presented.
- st_ready  output  1  buffer can accept a store this cycle.
- st_addr  input  32  store byte address.
- st_data  input  32  store data.
- st_mode  input  ldst_mode  store size.
- drain_en  input  1  permits draining, e.g. low while memory is being dumped.
- we  output  1  write enable to `mem`.
- wa  output  32  write address to `mem`.
- wd  output  32  write data to `mem`.
- wm  output  ldst_mode  write mode to `mem`.
- ld_addr  input  32  address of the load in flight.
- ld_mode  input  ldst_mode  mode of the load in flight.
- ld_fwd_valid  output  1  `ld_fwd_data` replaces the memory read word.
- ld_fwd_data  output  32  forwarded full word.
- ld_stall  output  1  load must wait for the buffer to drain further.
- count  output  DEPTH_LOG+1  number of occupied entries.
- empty  output  1  count == 0.

Behaviour:
- Storage: circular FIFO of {addr, data, mode}, with head pointer (oldest), tail pointer and count registers. Pointers wrap modulo DEPTH.
- Reset, synchronous and active-high:
  - head = tail = count = 0; `empty` = 1; `st_ready` = 1; `we` = 0; `ld_fwd_valid` = 0; `ld_stall` = 0.
  - Entry payloads are not cleared.
  - Reset mid-operation discards all pending stores. No write is issued in the reset cycle or after it.
- Push:
  - `st_ready` = (count < DEPTH). A registered or combinational form is acceptable, but `st_ready` must not depend on `st_valid`.
  - On posedge with `st_valid & st_ready`: write the entry at tail, then tail++.
  - When full, `st_ready` = 0 even if a pop occurs the same cycle. There is no full-bypass.
- Drain:
  - `we` = !empty & drain_en & !reset, combinational.
  - `wa/wd/wm` = head entry fields, combinational. They are don't-care when `we` = 0 but are driven from head.
  - On posedge with `we` = 1: head++. `mem` captures the write on the same edge.
- Latency: a store accepted at edge N appears on `we` in cycle N+1 at the earliest, if the buffer was empty.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Forwarding (combinational; considers registered entries only, not the store being pushed this cycle):
  - An entry matches when it is valid and addr[31:2] == ld_addr[31:2].
  - The youngest matching entry decides the result:
    - If its mode is LDST_W: `ld_fwd_valid` = 1, `ld_fwd_data` = its data, `ld_stall` = 0.
    - If its mode is sub-word: `ld_stall` = 1, `ld_fwd_valid` = 0.
  - No match: both outputs 0; `ld_fwd_data` = 0.
  - `ld_mode` does not affect matching. Byte/half extraction is done by the consumer.
- "Valid" means the entry index lies in [head, head+count) modulo DEPTH. Entries already popped never match.
- `drain_en` = 0 freezes draining; pushes continue until full.

Decomposition:
- Shared package (existing, which already holds `ldst_mode`): enum `ldst_mode` {LDST_B, LDST_H, LDST_W, LDST_BU, LDST_HU}, 3 bits.
- Add a packed struct `sb_entry_t` {addr[31:0], data[31:0], mode} to the package.
- One sub-module, `sb_fwd_search`:
  - Inputs: entry array, valid vector, head pointer, ld_addr.
  - Outputs: hit, hit_is_word, hit_data.
  - Youngest-first priority search.
- FIFO control stays in `store_buffer`.

Test Plan:
- Reset then idle → `empty` = 1, `st_ready` = 1, `we` = 0, count = 0.
- Push SW 0x0000_0010 / 0xDEAD_BEEF with drain_en = 1 → next cycle `we` = 1, `wa` = 0x10, `wd` = 0xDEADBEEF, `wm` = LDST_W; one cycle later `empty` = 1.
- drain_en = 0; push 5 stores (DEPTH = 4) → 4 accepted, `st_ready` = 0 on the 5th, count = 4. Then drain_en = 1 → 4 writes in order on 4 consecutive cycles, `st_ready` = 1 after the first pop.
- drain_en = 0; push SW 0x20 / 0x1111_1111 then SW 0x20 / 0x2222_2222; load ld_addr = 0x22, ld_mode = LDST_H → `ld_fwd_valid` = 1, `ld_fwd_data` = 0x22222222.
- drain_en = 0; push SW 0x30 / 0xAAAA_AAAA then SB 0x31 / 0x55; load 0x30 → `ld_stall` = 1. Enable drain → stall persists until SB is popped; load 0x40 → no stall, no forward.
- Push and pop in the same cycle at count = 2 over 2×DEPTH cycles (pointer wrap) → count stays 2 and write order matches push order. Assert reset mid-stream → no `we` from the next cycle, count = 0.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared load/store types plus the store buffer entry layout.
package store_buffer_pkg;

  // Access size of a load or store; the U variants are zero-extending loads.
  typedef enum logic [2:0] {
    LDST_B  = 3'd0,
    LDST_H  = 3'd1,
    LDST_W  = 3'd2,
    LDST_BU = 3'd3,
    LDST_HU = 3'd4
  } ldst_mode;

  // One buffered store: byte address, data as presented, and access size.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    ldst_mode    mode;
  } sb_entry_t;

  // Two byte addresses fall in the same 32-bit word.
  function automatic logic same_word(input logic [31:0] a, input logic [31:0] b);
    return a[31:2] == b[31:2];
  endfunction

endpackage

// File: rtl/store_buffer_fwd_search.sv
// Youngest-first search of the store buffer for a store that hits the load word.
module sb_fwd_search
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  sb_entry_t                    i_entries [DEPTH],
  input  logic [DEPTH-1:0]             i_valid,
  input  logic [$clog2(DEPTH)-1:0]     i_head,
  input  logic [31:0]                  i_ld_addr,
  output logic                         o_hit,
  output logic                         o_hit_is_word,
  output logic [31:0]                  o_hit_data
);

  localparam int DEPTH_LOG = $clog2(DEPTH);

  // Physical slot holding the entry of age k (0 = oldest).
  logic [DEPTH_LOG-1:0] w_age_idx [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_age
      assign w_age_idx[gi] = i_head + DEPTH_LOG'(gi);
    end
  endgenerate

  // Scan oldest to youngest so the last hit found is the youngest match.
  always_comb begin
    o_hit         = 1'b0;
    o_hit_is_word = 1'b0;
    o_hit_data    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (i_valid[w_age_idx[k]] && same_word(i_entries[w_age_idx[k]].addr, i_ld_addr)) begin
        o_hit         = 1'b1;
        o_hit_is_word = (i_entries[w_age_idx[k]].mode == LDST_W);
        o_hit_data    = i_entries[w_age_idx[k]].data;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// In-order store queue feeding the data-memory write port, with word-granular
// store-to-load forwarding or stall for the load path.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         st_valid,
  output logic                         st_ready,
  input  logic [31:0]                  st_addr,
  input  logic [31:0]                  st_data,
  input  ldst_mode                     st_mode,
  input  logic                         drain_en,
  output logic                         we,
  output logic [31:0]                  wa,
  output logic [31:0]                  wd,
  output ldst_mode                     wm,
  input  logic [31:0]                  ld_addr,
  input  ldst_mode                     ld_mode,
  output logic                         ld_fwd_valid,
  output logic [31:0]                  ld_fwd_data,
  output logic                         ld_stall,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         empty
);

  localparam int DEPTH_LOG = $clog2(DEPTH);

  sb_entry_t              r_entries [DEPTH];
  logic [DEPTH_LOG-1:0]   r_head;
  logic [DEPTH_LOG-1:0]   r_tail;
  logic [DEPTH_LOG:0]     r_count;

  logic                   w_push;
  logic                   w_pop;
  logic [DEPTH-1:0]       w_valid;
  logic                   w_hit;
  logic                   w_hit_is_word;
  logic [31:0]            w_hit_data;
  sb_entry_t              w_head_entry;

  // Byte/half selection of a forwarded word belongs to the consumer, so the
  // load size never influences matching.
  logic                   w_unused_ld_mode;
  assign w_unused_ld_mode = ^ld_mode;

  assign empty    = (r_count == '0);
  assign count    = r_count;
  // Depends only on occupancy: a pop in the same cycle never frees a full buffer.
  assign st_ready = (r_count < (DEPTH_LOG + 1)'(DEPTH));
  assign w_push   = st_valid & st_ready;

  assign w_head_entry = r_entries[r_head];
  assign we    = !empty & drain_en & !reset;
  assign wa    = w_head_entry.addr;
  assign wd    = w_head_entry.data;
  assign wm    = w_head_entry.mode;
  assign w_pop = we;

  // A slot is live when its distance from head is below the occupancy.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_valid
      logic [DEPTH_LOG-1:0] w_offset;
      assign w_offset    = DEPTH_LOG'(gi) - r_head;
      assign w_valid[gi] = ({1'b0, w_offset} < r_count);
    end
  endgenerate

  sb_fwd_search #(
    .DEPTH (DEPTH)
  ) u_fwd_search (
    .i_entries     (r_entries),
    .i_valid       (w_valid),
    .i_head        (r_head),
    .i_ld_addr     (ld_addr),
    .o_hit         (w_hit),
    .o_hit_is_word (w_hit_is_word),
    .o_hit_data    (w_hit_data)
  );

  // A word store can be forwarded whole; a sub-word store forces the load to wait.
  assign ld_fwd_valid = w_hit & w_hit_is_word & !reset;
  assign ld_stall     = w_hit & !w_hit_is_word & !reset;
  assign ld_fwd_data  = ld_fwd_valid ? w_hit_data : 32'h0;

  // Head/tail/occupancy bookkeeping; reset drops every pending store.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload capture at tail; payloads are left untouched by reset.
  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      r_entries[r_tail] <= '{addr: st_addr, data: st_data, mode: st_mode};
    end
  end

endmodule
